chunk_serial_adder: RTL and testbench

CHUNK_SERIAL_ADDER -- requirements
Module: chunk_serial_adder

---
 rtl/chunk_serial_adder_pkg.sv | 14 +
 rtl/lookahead_adder.sv | 27 ++
 rtl/chunk_serial_adder.sv | 141 ++++++++++++++
 tb/tb_chunk_serial_adder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/chunk_serial_adder_pkg.sv
// Shared definitions for the chunk-serial adder.
// Provides the FSM state encoding and the per-step chunk width.
package chunk_serial_adder_pkg;

    // Bits consumed per RUN step.
    localparam int unsigned CHUNK = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/lookahead_adder.sv
// 2-bit carry-lookahead adder used as the per-chunk datapath.
// Ports:
//   a, b : 2-bit operands
//   ci   : carry-in
//   s    : 2-bit sum
//   co   : carry-out
module lookahead_adder (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       ci,
    output logic [1:0] s,
    output logic       co
);

    logic [1:0] g;
    logic [1:0] p;
    logic       c1;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & ci);
        co = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        s  = p ^ {c1, ci};
    end

endmodule

// File: rtl/chunk_serial_adder.sv
// Serial adder that processes WIDTH-bit operands two bits per clock, LSB first.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   start : begin an addition (accepted in idle or done)
//   a, b  : operands, latched on the accept edge
//   ci    : carry-in, latched on the accept edge
//   busy  : high while chunks are being added
//   done  : one-cycle pulse when sum/co have just been updated
//   sum   : registered sum
//   co    : registered carry-out
module chunk_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    import chunk_serial_adder_pkg::*;

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sum_q;
    logic             co_q;

    logic             load;
    logic             step;
    logic             last;
    int unsigned      pos;
    logic [CHUNK-1:0] op_a, op_b, chunk_sum;
    logic             chunk_co;
    logic [WIDTH-1:0] acc_next;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and decoded outputs
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Chunk selection and accumulator insert
    always_comb begin
        last     = (k_q == KW'(N - 1));
        pos      = 32'(k_q) * CHUNK;
        op_a     = a_q[pos +: CHUNK];
        op_b     = b_q[pos +: CHUNK];
        acc_next = acc_q;
        acc_next[pos +: CHUNK] = chunk_sum;
    end

    lookahead_adder u_lookahead_adder (
        .a  (op_a),
        .b  (op_b),
        .ci (carry_q),
        .s  (chunk_sum),
        .co (chunk_co)
    );

    // Datapath registers. sum/co only change on the final RUN edge so they
    // stay stable for the whole of the following operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else if (load) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= ci;
            k_q     <= '0;
            acc_q   <= '0;
        end else if (step) begin
            acc_q   <= acc_next;
            carry_q <= chunk_co;
            // Explicit wrap keeps k aligned with RUN->DONE when N is not a power of two.
            k_q     <= last ? '0 : k_q + KW'(1);
            if (last) begin
                sum_q <= acc_next;
                co_q  <= chunk_co;
            end
        end
    end

    assign sum = sum_q;
    assign co  = co_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Self-checking bench for chunk_serial_adder (WIDTH=8): directed cases plus a
// randomized sweep against a plain-arithmetic reference model.
module tb_chunk_serial_adder;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             ci;
    logic             busy, done;
    logic [WIDTH-1:0] sum;
    logic             co;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH:0] cur_exp  = '0;
    logic [WIDTH:0] prev_exp = '0;

    always #5 clk = ~clk;

    chunk_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic c);
        longint t;
        t = longint'(x) + longint'(y) + longint'(c);
        return t[WIDTH:0];
    endfunction

    // Drive start for one edge with the given operands; returns just after accept.
    task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tci);
        a        = ta;
        b        = tb;
        ci       = tci;
        start    = 1'b1;
        prev_exp = cur_exp;
        cur_exp  = ref_add(ta, tb, tci);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done, scrambling operand inputs (they must not matter after accept).
    task automatic wait_done(input bit mid_pulse, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 4 * N) begin
            if (busy === 1'b1) busy_cnt++;
            check("stable_in_run", 32'({co, sum}), 32'(prev_exp));
            a  = WIDTH'($urandom);
            b  = WIDTH'($urandom);
            ci = 1'($urandom);
            if (mid_pulse && lat == 1) start = 1'b1;
            if (mid_pulse && lat == 2) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("done_busy_overlap", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb, input logic tci, input bit mid_pulse);
        int lat, bc;
        launch(ta, tb, tci);
        wait_done(mid_pulse, lat, bc);
        check({tag, "_latency"}, 32'(lat), 32'(N));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(N));
        check({tag, "_result"}, 32'({co, sum}), 32'(cur_exp));
        @(negedge clk);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'({co, sum}), 32'(cur_exp));
    endtask

    initial begin
        int lat, bc;

        // Reset with start asserted: reset must win.
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        ci    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'({co, sum}), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        run_op("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        check("ff_plus_01_exp", 32'({co, sum}), 32'h100);
        run_op("5a_plus_25", 8'h5A, 8'h25, 1'b1, 1'b1);
        check("5a_plus_25_exp", 32'({co, sum}), 32'h080);

        // Back-to-back: start held through the first DONE cycle.
        launch(8'h33, 8'h44, 1'b0);
        wait_done(1'b0, lat, bc);
        check("b2b_first", 32'({co, sum}), 32'(cur_exp));
        launch(8'h0F, 8'hF0, 1'b1);
        wait_done(1'b0, lat, bc);
        check("b2b_gap", 32'(lat + 1), 32'(N + 1));
        check("b2b_second", 32'({co, sum}), 32'h100);
        @(negedge clk);
        check("b2b_idle", 32'(done), 32'd0);

        // Reset on E2 of a run.
        launch(8'hA7, 8'h3C, 1'b1);
        check("mid_rst_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_result", 32'({co, sum}), 32'd0);
        rst_n    = 1'b1;
        cur_exp  = '0;
        prev_exp = '0;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            check("mid_rst_no_done", 32'(done), 32'd0);
        end

        // Random sweep
        for (int i = 0; i < 1000; i++) begin
            run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
